// File: rtl/cdb_pkg.sv
// Shared types and helpers for the CDB write-port arbiter.
// Age compares are made relative to the ROB head so that index wrap-around is handled.
package cdb_pkg;

  localparam int ROB_SIZE = 8;
  localparam int ROB_IXW  = $clog2(ROB_SIZE);
  localparam int N_REQ    = 4;
  localparam int GNT_W    = $clog2(N_REQ);

  localparam int REQ_ALU  = 0;
  localparam int REQ_MUL  = 1;
  localparam int REQ_DIV  = 2;
  localparam int REQ_LOAD = 3;

  typedef struct packed {
    logic [ROB_IXW-1:0] rob_ix;
    logic [31:0]        value;
    logic [31:0]        dest;
  } cdb_result_t;

  function automatic logic [ROB_IXW-1:0] age(input logic [ROB_IXW-1:0] ix,
                                             input logic [ROB_IXW-1:0] head);
    return ix - head;
  endfunction

  function automatic logic is_younger(input logic [ROB_IXW-1:0] ix,
                                      input logic [ROB_IXW-1:0] branch_ix,
                                      input logic [ROB_IXW-1:0] head);
    return age(ix, head) > age(branch_ix, head);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester, flush and broadcast signals of the CDB arbiter.
// The slave modport is the arbiter; master is the FU/ROB side.
interface cdb_arbiter_if;
  import cdb_pkg::*;

  logic [N_REQ-1:0]         fu_valid_in;
  logic [N_REQ-1:0]         fu_ready_out;
  logic [N_REQ*ROB_IXW-1:0] fu_rob_ix_in;
  logic [N_REQ*32-1:0]      fu_value_in;
  logic [N_REQ*32-1:0]      fu_dest_in;
  logic [ROB_IXW-1:0]       rob_head_ix_in;
  logic                     flush_in;
  logic [ROB_IXW-1:0]       flush_branch_ix_in;
  logic                     cdb_hold_in;
  logic                     cdb_valid_out;
  logic [ROB_IXW-1:0]       cdb_rob_ix_out;
  logic [31:0]              cdb_value_out;
  logic [31:0]              cdb_dest_out;
  logic [GNT_W-1:0]         grant_ix_out;

  modport slave (
    input  fu_valid_in, fu_rob_ix_in, fu_value_in, fu_dest_in,
    input  rob_head_ix_in, flush_in, flush_branch_ix_in, cdb_hold_in,
    output fu_ready_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out,
    output cdb_dest_out, grant_ix_out
  );

  modport master (
    output fu_valid_in, fu_rob_ix_in, fu_value_in, fu_dest_in,
    output rob_head_ix_in, flush_in, flush_branch_ix_in, cdb_hold_in,
    input  fu_ready_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out,
    input  cdb_dest_out, grant_ix_out
  );

endinterface

// File: rtl/cdb_slot.sv
// One-entry holding register for a single requester's result.
// A load wins over drain/squash so a same-cycle refill keeps the slot occupied.
module cdb_slot
  import cdb_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_squash,
  input  cdb_result_t i_data,
  output logic        o_valid,
  output cdb_result_t o_data
);

  logic        r_valid;
  cdb_result_t r_data;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drain || i_squash) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the ROB's single CDB write port between N_REQ units.
// Results are parked in per-requester slots and broadcast through a registered output.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_n_in,
  cdb_arbiter_if.slave bus
);

  cdb_result_t      w_fu_data   [N_REQ];
  cdb_result_t      w_slot_data [N_REQ];
  logic [N_REQ-1:0] w_slot_v;
  logic [N_REQ-1:0] w_load;
  logic [N_REQ-1:0] w_squash;
  logic [N_REQ-1:0] w_ready;
  logic [N_REQ-1:0] w_gnt_vec;
  logic             w_found;
  logic             w_gnt_v;
  logic [GNT_W-1:0] w_gnt_ix;
  logic [GNT_W-1:0] w_rr_nxt;

  logic             r_cdb_v;
  cdb_result_t      r_cdb;
  logic [GNT_W-1:0] r_gnt_ix;
  logic [GNT_W-1:0] r_rr_ptr;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    assign w_fu_data[i] = {bus.fu_rob_ix_in[i*ROB_IXW +: ROB_IXW],
                           bus.fu_value_in[i*32 +: 32],
                           bus.fu_dest_in[i*32 +: 32]};

    assign w_ready[i] = !w_slot_v[i] || w_gnt_vec[i];

    // Younger handshakes during a flush complete but are dropped.
    assign w_load[i] = bus.fu_valid_in[i] && w_ready[i] &&
                       !(bus.flush_in && is_younger(w_fu_data[i].rob_ix,
                                                    bus.flush_branch_ix_in,
                                                    bus.rob_head_ix_in));

    assign w_squash[i] = bus.flush_in && w_slot_v[i] &&
                         is_younger(w_slot_data[i].rob_ix, bus.flush_branch_ix_in,
                                    bus.rob_head_ix_in);

    cdb_slot u_slot (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .i_load   (w_load[i]),
      .i_drain  (w_gnt_vec[i]),
      .i_squash (w_squash[i]),
      .i_data   (w_fu_data[i]),
      .o_valid  (w_slot_v[i]),
      .o_data   (w_slot_data[i])
    );
  end

  always_comb begin
    int t;
    w_found  = 1'b0;
    w_gnt_ix = '0;
    for (int k = 0; k < N_REQ; k++) begin
      t = int'(r_rr_ptr) + k;
      if (t >= N_REQ) t = t - N_REQ;
      if (!w_found && w_slot_v[GNT_W'(t)]) begin
        w_found  = 1'b1;
        w_gnt_ix = GNT_W'(t);
      end
    end
  end

  assign w_gnt_v   = w_found && !bus.cdb_hold_in && !bus.flush_in;
  assign w_gnt_vec = w_gnt_v ? (N_REQ'(1) << w_gnt_ix) : '0;
  assign w_rr_nxt  = (w_gnt_ix == GNT_W'(N_REQ - 1)) ? '0 : w_gnt_ix + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cdb_v  <= 1'b0;
      r_cdb    <= '0;
      r_gnt_ix <= '0;
      r_rr_ptr <= '0;
    end else if (w_gnt_v) begin
      r_cdb_v  <= 1'b1;
      r_cdb    <= w_slot_data[w_gnt_ix];
      r_gnt_ix <= w_gnt_ix;
      r_rr_ptr <= w_rr_nxt;
    end else if (bus.flush_in && r_cdb_v &&
                 is_younger(r_cdb.rob_ix, bus.flush_branch_ix_in, bus.rob_head_ix_in)) begin
      r_cdb_v <= 1'b0;
    end else if (!bus.cdb_hold_in) begin
      r_cdb_v <= 1'b0;
    end
  end

  assign bus.fu_ready_out   = w_ready;
  assign bus.cdb_valid_out  = r_cdb_v;
  assign bus.cdb_rob_ix_out = r_cdb.rob_ix;
  assign bus.cdb_value_out  = r_cdb.value;
  assign bus.cdb_dest_out   = r_cdb.dest;
  assign bus.grant_ix_out   = r_gnt_ix;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a slot/round-robin model built from plain arrays.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  logic [N_REQ-1:0]   t_valid;
  logic [ROB_IXW-1:0] t_rix [N_REQ];
  logic [31:0]        t_val [N_REQ];
  logic [31:0]        t_dst [N_REQ];
  logic [ROB_IXW-1:0] t_head, t_br;
  logic               t_flush, t_hold;

  always_comb begin
    bus.fu_valid_in        = t_valid;
    bus.rob_head_ix_in     = t_head;
    bus.flush_in           = t_flush;
    bus.flush_branch_ix_in = t_br;
    bus.cdb_hold_in        = t_hold;
    bus.fu_rob_ix_in       = '0;
    bus.fu_value_in        = '0;
    bus.fu_dest_in         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.fu_rob_ix_in[i*ROB_IXW +: ROB_IXW] = t_rix[i];
      bus.fu_value_in[i*32 +: 32]            = t_val[i];
      bus.fu_dest_in[i*32 +: 32]             = t_dst[i];
    end
  end

  int tests = 0;
  int fails = 0;

  // Model state: slot contents, round-robin pointer, broadcast register.
  bit          m_v   [N_REQ];
  int          m_rix [N_REQ];
  logic [31:0] m_val [N_REQ];
  logic [31:0] m_dst [N_REQ];
  int          m_rr;
  bit          m_cv;
  int          m_crix, m_gix;
  logic [31:0] m_cval, m_cdst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int agef(input int x, input int h);
    return ((x - h) % ROB_SIZE + ROB_SIZE) % ROB_SIZE;
  endfunction

  function automatic bit young(input int x);
    return agef(x, int'(t_head)) > agef(int'(t_br), int'(t_head));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_REQ; i++) begin
      m_v[i] = 0; m_rix[i] = 0; m_val[i] = '0; m_dst[i] = '0;
    end
    m_rr = 0; m_cv = 0; m_crix = 0; m_gix = 0; m_cval = '0; m_cdst = '0;
  endtask

  task automatic clear_inputs();
    t_valid = '0; t_head = '0; t_br = '0; t_flush = 0; t_hold = 0;
    for (int i = 0; i < N_REQ; i++) begin
      t_rix[i] = '0; t_val[i] = '0; t_dst[i] = '0;
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic step();
    bit          gok;
    int          w;
    logic [N_REQ-1:0] exp_ready;
    bit          nv [N_REQ];
    #1;
    gok = 0; w = 0;
    if (!t_hold && !t_flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        int j;
        j = (m_rr + k) % N_REQ;
        if (!gok && m_v[j]) begin gok = 1; w = j; end
      end
    end
    for (int i = 0; i < N_REQ; i++) exp_ready[i] = !m_v[i] || (gok && w == i);
    chk("fu_ready", bus.fu_ready_out, exp_ready);
    chk("cdb_valid", bus.cdb_valid_out, m_cv);
    chk("cdb_rob_ix", bus.cdb_rob_ix_out, m_crix);
    chk("cdb_value", bus.cdb_value_out, m_cval);
    chk("cdb_dest", bus.cdb_dest_out, m_cdst);
    chk("grant_ix", bus.grant_ix_out, m_gix);
    @(posedge clk);
    if (gok) begin
      m_cv = 1; m_crix = m_rix[w]; m_cval = m_val[w]; m_cdst = m_dst[w];
      m_gix = w; m_rr = (w + 1) % N_REQ;
    end else if (t_flush && m_cv && young(m_crix)) begin
      m_cv = 0;
    end else if (!t_hold) begin
      m_cv = 0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      nv[i] = m_v[i];
      if (t_valid[i] && exp_ready[i]) begin
        if (t_flush && young(int'(t_rix[i]))) nv[i] = 0;
        else begin
          nv[i] = 1; m_rix[i] = int'(t_rix[i]); m_val[i] = t_val[i]; m_dst[i] = t_dst[i];
        end
      end else if (gok && w == i) nv[i] = 0;
      else if (t_flush && m_v[i] && young(m_rix[i])) nv[i] = 0;
      m_v[i] = nv[i];
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #1;
    chk("reset_valid", bus.cdb_valid_out, 0);
    chk("reset_ready", bus.fu_ready_out, 4'hF);
    chk("reset_grant", bus.grant_ix_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: four results in one cycle drain in slot order 0..3.
    t_valid = 4'hF;
    for (int i = 0; i < N_REQ; i++) begin
      t_rix[i] = ROB_IXW'(i); t_val[i] = 32'hA0 + i; t_dst[i] = 32'h10 * i;
    end
    step();
    t_valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      step();
      chk("contend_grant", bus.grant_ix_out, k);
      chk("contend_rix", bus.cdb_rob_ix_out, k);
      chk("contend_valid", bus.cdb_valid_out, 1);
    end
    step();
    chk("contend_done", bus.cdb_valid_out, 0);

    // Single ALU result: two edges to broadcast, gone on the third.
    t_valid = 4'b0001; t_rix[REQ_ALU] = 3'd3; t_val[REQ_ALU] = 32'h55; t_dst[REQ_ALU] = '0;
    step();
    t_valid = '0;
    chk("single_e0", bus.cdb_valid_out, 0);
    step();
    chk("single_valid", bus.cdb_valid_out, 1);
    chk("single_rix", bus.cdb_rob_ix_out, 3);
    chk("single_value", bus.cdb_value_out, 32'h55);
    chk("single_grant", bus.grant_ix_out, 0);
    step();
    chk("single_e2", bus.cdb_valid_out, 0);

    // Back-to-back MUL results with no bubbles.
    for (int c = 0; c < 8; c++) begin
      t_valid = 4'b0010; t_rix[REQ_MUL] = ROB_IXW'(c); t_val[REQ_MUL] = 32'h100 + c;
      step();
      chk("b2b_ready", bus.fu_ready_out[REQ_MUL], 1);
      if (c > 0) begin
        chk("b2b_valid", bus.cdb_valid_out, 1);
        chk("b2b_value", bus.cdb_value_out, 32'h100 + c - 1);
      end
    end
    t_valid = '0;
    step(); step(); step();

    // Hold: slots 0 and 2 retained while frozen, then drain from rr_ptr=2.
    t_valid = 4'b0101; t_rix[REQ_ALU] = 3'd1; t_val[REQ_ALU] = 32'hB1;
    t_rix[REQ_DIV] = 3'd2; t_val[REQ_DIV] = 32'hB2;
    step();
    t_valid = '0; t_hold = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_ready", bus.fu_ready_out, 4'b1010);
      chk("hold_valid", bus.cdb_valid_out, 0);
    end
    t_hold = 0;
    step();
    chk("unhold1_grant", bus.grant_ix_out, 2);
    chk("unhold1_rix", bus.cdb_rob_ix_out, 2);
    step();
    chk("unhold2_grant", bus.grant_ix_out, 0);
    chk("unhold2_value", bus.cdb_value_out, 32'hB1);
    step();

    // Flush with wrap: head 6, branch 7; rob 0 is younger, rob 6 is older.
    t_head = 3'd6;
    t_valid = 4'b0011; t_rix[REQ_ALU] = 3'd0; t_val[REQ_ALU] = 32'hC0;
    t_rix[REQ_MUL] = 3'd6; t_val[REQ_MUL] = 32'hC6;
    step();
    t_valid = '0; t_flush = 1; t_br = 3'd7;
    step();
    chk("flush_nobcast", bus.cdb_valid_out, 0);
    t_flush = 0;
    step();
    chk("flush_valid", bus.cdb_valid_out, 1);
    chk("flush_rix", bus.cdb_rob_ix_out, 6);
    chk("flush_grant", bus.grant_ix_out, 1);
    step();
    chk("flush_squashed", bus.cdb_valid_out, 0);

    // Asynchronous reset while a broadcast is on the bus.
    t_head = '0;
    t_valid = 4'b1000; t_rix[REQ_LOAD] = 3'd5; t_val[REQ_LOAD] = 32'hD5;
    step();
    t_valid = '0;
    step();
    chk("prereset_valid", bus.cdb_valid_out, 1);
    rst_n = 1'b0;
    #1;
    chk("areset_valid", bus.cdb_valid_out, 0);
    chk("areset_ready", bus.fu_ready_out, 4'hF);
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional flush and hold.
    for (int c = 0; c < 600; c++) begin
      t_valid = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        t_rix[i] = ROB_IXW'($urandom);
        t_val[i] = $urandom;
        t_dst[i] = $urandom_range(0, 3) == 0 ? $urandom : 32'h0;
      end
      t_head  = ROB_IXW'($urandom);
      t_br    = ROB_IXW'($urandom);
      t_flush = ($urandom_range(0, 7) == 0);
      t_hold  = ($urandom_range(0, 3) == 0);
      step();
    end
    clear_inputs();
    for (int c = 0; c < 6; c++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) write port of the reorder buffer between N_REQ functional-unit requesters (ALU, MUL, DIV, load buffer).
- Each requester hands off one result into a private holding slot. A round-robin scheduler picks one occupied slot per cycle and drives a registered CDB broadcast to the ROB and the reservation stations.
- On a branch mispredict, results younger than the branch are squashed.

Parameters:
- ROB_SIZE, 8, ROB entry count; ROB_IXW = $clog2(ROB_SIZE).
- N_REQ, 4, number of requesters; slot 0 = ALU, 1 = MUL, 2 = DIV, 3 = LOAD.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- fu_valid_in  input  N_REQ  per-requester result valid.
- fu_ready_out  output  N_REQ  per-requester slot can accept this cycle.
- fu_rob_ix_in  input  N_REQ*ROB_IXW  flattened ROB index; requester i occupies bits [i*ROB_IXW +: ROB_IXW].
- fu_value_in  input  N_REQ*32  flattened result value.
- fu_dest_in  input  N_REQ*32  flattened store address offset (0 for non-stores).
- rob_head_ix_in  input  ROB_IXW  current ROB head, used for age compare.
- flush_in  input  1  mispredict flush pulse, one cycle.
- flush_branch_ix_in  input  ROB_IXW  ROB index of the mispredicted branch.
- cdb_hold_in  input  1  consumer cannot take a new broadcast; freeze the output.
- cdb_valid_out  output  1  broadcast valid.
- cdb_rob_ix_out  output  ROB_IXW  broadcast ROB index.
- cdb_value_out  output  32  broadcast value.
- cdb_dest_out  output  32  broadcast dest offset.
- grant_ix_out  output  $clog2(N_REQ)  requester of the current broadcast.

Behaviour:
- Reset (async assert, sync release):
  - all slots empty; rr_ptr = 0.
  - cdb_valid_out = 0; cdb_rob_ix_out, cdb_value_out, cdb_dest_out = 0; grant_ix_out = 0.
  - fu_ready_out = all ones.
- Reset mid-operation discards all slot contents and the output register immediately.
- Slot handshake:
  - fu_ready_out[i] = !slot_v[i] | grant[i] (combinational); a requester may hand off in the same cycle its slot drains.
  - Transfer occurs when fu_valid_in[i] & fu_ready_out[i] at the rising edge; the slot latches rob_ix, value and dest.
- Grant:
  - Combinational search over slot_v, starting at rr_ptr and wrapping modulo N_REQ; the first occupied slot wins.
  - Grant is suppressed when cdb_hold_in or flush_in is high.
- On a grant to w:
  - The output register loads slot w and grant_ix_out = w; cdb_valid_out = 1 next cycle.
  - slot w clears unless it is refilled in the same cycle.
  - rr_ptr <= (w+1) mod N_REQ.
- No grant, no hold: cdb_valid_out <= 0 and rr_ptr is unchanged.
- cdb_hold_in high: output register and rr_ptr hold their values; slots keep their contents.
- Latency: minimum 2 edges from fu_valid_in handshake to cdb_valid_out = 1. At most one broadcast per cycle. Sustained throughput is 1 result/cycle.
- Fairness: a continuously requesting slot is granted within N_REQ cycles of non-held operation.
- Age rule:
  - age(x) = (x - rob_head_ix_in) mod ROB_SIZE, computed in ROB_IXW bits.
  - x is younger than the branch iff age(x) > age(flush_branch_ix_in).
  - The branch itself is not squashed.
- Flush cycle (flush_in = 1):
  - Occupied slots holding younger entries clear.
  - Incoming handshakes carrying younger indices are accepted (ready honoured) but not stored.
  - The output register clears cdb_valid_out if its index is younger; otherwise it follows the hold/no-grant rules.
  - No grant is issued that cycle.
- Simultaneous flush and hold: flush squashing applies; hold still freezes rr_ptr.
- Wrap-around: index compares are always done through age(), never through raw indices.

Decomposition:
- Shared package cdb_pkg:
  - the CDB result struct (rob_ix, value, dest);
  - the age() function;
  - requester index localparams REQ_ALU, REQ_MUL, REQ_DIV, REQ_LOAD.
- Sub-module cdb_slot: one-entry holding register with load, drain and squash inputs; instantiated N_REQ times.
- The round-robin pick stays in cdb_arbiter.

Test Plan:
- Single result: ALU handshake rob_ix=3, value=0x55 at edge 0, head=0 -> cdb_valid_out=1, cdb_rob_ix_out=3, value 0x55, grant_ix_out=0 after edge 1; cdb_valid_out=0 after edge 2.
- Contention: all four slots loaded with rob_ix 0..3 the same cycle, rr_ptr=0 -> broadcasts in order 0,1,2,3 on four consecutive cycles; then rr_ptr=0.
- Back-to-back: MUL asserts valid continuously with a new rob_ix each cycle, others idle -> fu_ready_out[1] stays 1, one broadcast per cycle, no bubbles.
- Hold: two slots full, cdb_hold_in=1 for 3 cycles -> outputs frozen, both slots retained, fu_ready_out=0 for those slots; after release, the remaining slot broadcasts.
- Flush with wrap: head=6, branch=7, slots hold 0 (age 2, younger) and 6 (age 0, older), flush_in=1 -> slot with 0 cleared; 6 broadcast next cycle; no broadcast during the flush cycle.
- Async reset mid-broadcast: drop rst_n_in between edges with cdb_valid_out=1 -> cdb_valid_out=0 immediately; fu_ready_out all ones.
